// File: rtl/reset_sequencer_if.sv
// Request/acknowledge, status-in and reset-out bundle of the staged reset sequencer.
interface reset_sequencer_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] ack_o;
    logic               mmcms_locked_i;
    logic               idlyrdy_i;
    logic               gbt_ready_i;
    logic               core_reset_o;
    logic               link_reset_o;
    logic               trig_reset_o;
    logic               busy_o;
    logic [2:0]         last_src_o;
    logic [7:0]         seq_count_o;
    logic               timeout_o;

    modport slave (
        input  req_i, mmcms_locked_i, idlyrdy_i, gbt_ready_i,
        output ack_o, core_reset_o, link_reset_o, trig_reset_o,
        output busy_o, last_src_o, seq_count_o, timeout_o
    );

    modport master (
        output req_i, mmcms_locked_i, idlyrdy_i, gbt_ready_i,
        input  ack_o, core_reset_o, link_reset_o, trig_reset_o,
        input  busy_o, last_src_o, seq_count_o, timeout_o
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged soft-reset controller: coalesces requests, delays for the ack, asserts, then releases core/links/trigger in order.
// Optional WAIT_LOCK watchdog is built only when RESET_SEQ_TIMEOUT_EN is defined.
module reset_sequencer #(
    parameter int NUM_REQ      = 3,
    parameter int ACK_DELAY    = 1023,
    parameter int STAGE_HOLD   = 31,
    parameter int LOCK_TIMEOUT = 2**20-1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    reset_sequencer_if.slave  bus
);
    localparam int MAX_A = (ACK_DELAY > STAGE_HOLD) ? ACK_DELAY : STAGE_HOLD;
    localparam int MAX_V = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
    localparam int CW    = $clog2(MAX_V) + 1;

    localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_DELAY - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(STAGE_HOLD - 1);
    localparam logic [CW-1:0] HOLD_FULL = CW'(STAGE_HOLD);

    typedef enum logic [2:0] {
        S_DELAY, S_ASSERT, S_WAIT_LOCK, S_REL_CORE, S_REL_LINK, S_RUN
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] ack_q;
    logic               core_rst_q;
    logic               link_rst_q;
    logic               trig_rst_q;
    logic               busy_q;
    logic [2:0]         last_src_q;
    logic [7:0]         seq_count_q;

    logic       lock_ok;
    logic       all_good;
    logic       lock_release;
    logic       abort;
    logic       timeout_hit;
    logic       to_assert;
    logic [2:0] grant_idx;

    assign lock_ok      = bus.mmcms_locked_i & bus.gbt_ready_i;
    assign all_good     = lock_ok & bus.idlyrdy_i;
    assign lock_release = (state == S_WAIT_LOCK) && all_good && (cnt == HOLD_FULL);

    // IDELAYCTRL readiness only gates the initial release; a running system survives its glitches.
    assign abort = !lock_ok && ((state == S_DELAY) || (state == S_REL_CORE) ||
                                (state == S_REL_LINK) || (state == S_RUN));

`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);
    logic [CW-1:0] wd_cnt;
    logic          timeout_q;

    assign timeout_hit = (state == S_WAIT_LOCK) && !lock_release && (wd_cnt == TO_LAST);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wd_cnt    <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
            wd_cnt    <= (state == S_WAIT_LOCK) ? wd_cnt + 1'b1 : '0;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign timeout_hit   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign to_assert = abort || timeout_hit || ((state == S_DELAY) && (cnt == ACK_LAST));

    always_comb begin
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pending[i]) grant_idx = 3'(i);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state       <= S_WAIT_LOCK;
            cnt         <= '0;
            pending     <= '0;
            ack_q       <= '0;
            core_rst_q  <= 1'b1;
            link_rst_q  <= 1'b1;
            trig_rst_q  <= 1'b1;
            busy_q      <= 1'b1;
            last_src_q  <= '0;
            seq_count_q <= '0;
        end else begin
            ack_q   <= '0;
            pending <= pending | bus.req_i;
            cnt     <= cnt + 1'b1;

            if (to_assert) begin
                state      <= S_ASSERT;
                cnt        <= '0;
                core_rst_q <= 1'b1;
                link_rst_q <= 1'b1;
                trig_rst_q <= 1'b1;
                busy_q     <= 1'b1;
            end else begin
                case (state)
                    S_ASSERT: begin
                        if (cnt == HOLD_LAST) begin
                            state <= S_WAIT_LOCK;
                            cnt   <= '0;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_release) begin
                            state      <= S_REL_CORE;
                            cnt        <= '0;
                            core_rst_q <= 1'b0;
                        end else if (!all_good) begin
                            cnt <= '0;
                        end
                    end
                    S_REL_CORE: begin
                        if (cnt == HOLD_LAST) begin
                            state      <= S_REL_LINK;
                            cnt        <= '0;
                            link_rst_q <= 1'b0;
                        end
                    end
                    S_REL_LINK: begin
                        if (cnt == HOLD_LAST) begin
                            state      <= S_RUN;
                            cnt        <= '0;
                            trig_rst_q <= 1'b0;
                            busy_q     <= 1'b0;
                            if (seq_count_q != 8'hFF) seq_count_q <= seq_count_q + 8'd1;
                        end
                    end
                    S_RUN: begin
                        // Every pending source is acked at once; requests landing this edge stay queued.
                        if (pending != '0) begin
                            state      <= S_DELAY;
                            cnt        <= '0;
                            ack_q      <= pending;
                            last_src_q <= grant_idx;
                            pending    <= bus.req_i;
                            busy_q     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.ack_o        = ack_q;
    assign bus.core_reset_o = core_rst_q;
    assign bus.link_reset_o = link_rst_q;
    assign bus.trig_reset_o = trig_rst_q;
    assign bus.busy_o       = busy_q;
    assign bus.last_src_o   = last_src_q;
    assign bus.seq_count_o  = seq_count_q;
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller for the OptoHybrid core. It arbitrates soft-reset requests from several sources (wishbone, TTC, SCA). It delays each granted request so the requester's response can leave the board, then asserts all downstream resets. Releases then happen in order (core, links, trigger) once clocking and GBT status are good, with a fixed hold time between stages. It sits between the clocking/GBT status signals and the reset inputs of the core, link and trigger logic.

## Interface
- NUM_REQ, 3, number of soft-reset requesters (1..8)
- ACK_DELAY, 1023, cycles between grant and reset assertion (>=1)
- STAGE_HOLD, 31, cycles per timed stage (>=1)
- LOCK_TIMEOUT, 2**20-1, watchdog limit in WAIT_LOCK (>=STAGE_HOLD)
- clock_i  in  1  core clock
- reset_i  in  1  asynchronous, active-high
- req_i  in  NUM_REQ  soft-reset request pulses, one bit per source
- ack_o  out  NUM_REQ  one-cycle acknowledge of serviced requests
- mmcms_locked_i  in  1  all MMCMs locked
- idlyrdy_i  in  1  IDELAYCTRL ready
- gbt_ready_i  in  1  GBT rx ready & rx valid & tx ready
- core_reset_o  out  1  core reset, active-high
- link_reset_o  out  1  link reset, active-high
- trig_reset_o  out  1  trigger reset, active-high
- busy_o  out  1  high in any state other than RUN
- last_src_o  out  3  index of the most recently granted requester
- seq_count_o  out  8  completed sequences, saturating at 255
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: DELAY, ASSERT, WAIT_LOCK, REL_CORE, REL_LINK, RUN. All outputs are registered.
- On reset_i, the state is WAIT_LOCK. All three resets are 1, busy_o=1, ack_o=0, last_src_o=0, seq_count_o=0, timeout_o=0, and the pending register is 0.
- pending[i] sets on req_i[i] in any state.
- RUN with pending != 0:
  - grant the lowest set index; last_src_o takes that index;
  - ack_o equals the whole pending mask for one cycle, and pending clears (coalescing);
  - go to DELAY.
- DELAY: resets stay low for ACK_DELAY cycles, then go to ASSERT.
- ASSERT: all resets are 1 for STAGE_HOLD cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - the stable counter increments while mmcms_locked_i & gbt_ready_i & idlyrdy_i, and clears on any 0;
  - at STAGE_HOLD consecutive good cycles, core_reset_o falls and the state goes to REL_CORE.
- REL_CORE: after STAGE_HOLD cycles, link_reset_o falls and the state goes to REL_LINK.
- REL_LINK: after STAGE_HOLD cycles, trig_reset_o falls, the state goes to RUN, and seq_count_o increments (saturating).
- Loss of mmcms_locked_i or gbt_ready_i in DELAY, REL_CORE, REL_LINK or RUN: go to ASSERT on the next edge and assert all resets. A DELAY aborted this way has already been acked.
- Requests arriving outside RUN are held in pending. They start a fresh sequence once RUN is reached.
- Counter widths are $clog2 of the largest of ACK_DELAY, STAGE_HOLD and LOCK_TIMEOUT, plus 1. The counter reloads on every state entry.

## Timing
- Request latency: req_i is sampled at edge k. ack_o and the DELAY entry take effect at edge k+1. Resets rise at edge k+1+ACK_DELAY.
- Release timing, with locks good from the first edge after reset_i falls:
  - core_reset_o falls at edge STAGE_HOLD+1;
  - link_reset_o falls STAGE_HOLD edges after core_reset_o;
  - trig_reset_o falls STAGE_HOLD edges after link_reset_o.
- Outputs change only on clock edges, except reset_i, which forces reset values asynchronously.
- Requests from several sources in the same cycle produce one ack_o cycle with all bits set. last_src_o takes the lowest index.

## Configuration
- RESET_SEQ_TIMEOUT_EN defined:
  - WAIT_LOCK also counts total cycles spent in the state;
  - at LOCK_TIMEOUT, timeout_o pulses for one cycle and the state goes to ASSERT, retrying the sequence.
- Undefined: WAIT_LOCK waits indefinitely, timeout_o is tied to 0, and the watchdog counter is not built.

## Test plan
- Power-up with STAGE_HOLD=4 and locks high from the first edge -> core_reset_o falls at edge 5, link_reset_o at edge 9, trig_reset_o at edge 13; busy_o=0 and seq_count_o=1.
- In RUN with ACK_DELAY=8, pulse req_i=3'b010 at edge k -> ack_o=3'b010 at k+1 only, last_src_o=1, all resets high at k+9, and the release sequence repeats; seq_count_o=2.
- req_i=3'b110 in the same cycle, then req_i[0] during ASSERT -> ack_o=3'b110 with last_src_o=1. A second sequence follows on reaching RUN with ack_o=3'b001 and last_src_o=0.
- Drop gbt_ready_i for 1 cycle during REL_LINK -> all resets high the next edge. WAIT_LOCK then restarts its STAGE_HOLD count from 0.
- With RESET_SEQ_TIMEOUT_EN and LOCK_TIMEOUT=16, hold mmcms_locked_i low -> timeout_o pulses every 16+STAGE_HOLD cycles and the resets stay high. Without the macro, timeout_o stays 0.
- Assert reset_i mid-DELAY -> all resets are 1 immediately, pending and ack_o are 0, and no sequence is counted.
